data_mem: RTL
=============

Name: data_mem

Overview:
- Read/write data memory for the load/store unit. Complements the read-only instruction memory.
- Word-addressed synchronous RAM behind a req/gnt/rvalid handshake, with byte enables and a configurable fixed response latency.
- One transaction outstanding at a time.
- Sits between the LSU and the data address space.

Parameters:
- AWIDTH, 8, word address width; depth = 2**AWIDTH words.
- DWIDTH, 32, data width; must be a multiple of 8.
- LATENCY, 1, cycles from request acceptance to response; legal range 1..4.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- req  input  1  request valid from the LSU.
- gnt  output  1  request accepted in the current cycle when req && gnt.
- we  input  1  1 = write, 0 = read; sampled at acceptance.
- be  input  DWIDTH/8  byte enables, write only; bit i covers wdata[8i+7:8i].
- addr  input  AWIDTH  word address; sampled at acceptance.
- wdata  input  DWIDTH  write data; sampled at acceptance.
- rvalid  output  1  response valid, exactly one cycle per accepted request.
- rdata  output  DWIDTH  read data; valid only while rvalid is high.

Behaviour:
- Reset: asynchronous, active-low (rst_n = 0).
  - Outputs: rvalid = 0, rdata = 0, gnt = 0 while rst_n = 0.
  - Internal: state = IDLE, latency counter = 0.
  - Memory array is not reset; contents are undefined until written.
- States:
  - IDLE: gnt = 1. req = 1 accepts the request. If LATENCY == 1 go to RESP, else go to WAIT with the counter loaded to 1.
  - WAIT: gnt = 0. The counter increments each cycle. When the counter reaches LATENCY-1, go to RESP.
  - RESP: rvalid = 1, gnt = 1. req = 1 accepts a new request (back-to-back) with the same transition rules as IDLE. Otherwise go to IDLE.
- Latency: a request accepted in cycle t gets rvalid high in cycle t+LATENCY, for one cycle only.
  - Throughput with continuous req is one request per LATENCY cycles.
  - With LATENCY = 1, one request per cycle.
- Write:
  - Committed at the acceptance clock edge, byte-wise per be.
  - Bytes with be[i] = 0 keep their old value.
  - be = 0 writes nothing but still produces a response.
  - Response has rdata = 0.
- Read:
  - The full word mem[addr] is captured at the acceptance edge, so it reflects all previously accepted writes.
  - be is ignored on reads.
  - rdata holds the captured word during the response cycle.
  - When rvalid = 0, rdata = 0.
- No request buffering:
  - req while gnt = 0 is ignored.
  - The LSU must hold req, we, addr, be and wdata until it sees gnt.
- Inputs are don't-care when req = 0. No side effects without acceptance.
- Address wrap: none needed; addr covers the full depth exactly.
- Reset mid-transaction:
  - A write already accepted stays committed.
  - A pending response is discarded; no rvalid is produced after reset release.
  - First cycle after reset release is IDLE with gnt = 1.
- Read-after-write to the same address in consecutive accepted requests returns the new data.

Test Plan:
- Reset/idle: hold rst_n = 0 for 3 cycles with req = 1 -> gnt = 0, rvalid = 0, rdata = 0. After release, gnt = 1 and no spurious rvalid.
- Write then read, LATENCY = 1:
  - Write addr 0x10, wdata 0xDEADBEEF, be = 0xF, accepted in cycle t -> rvalid at t+1 with rdata = 0.
  - Read addr 0x10 accepted at t+1 -> rvalid at t+2 with rdata = 0xDEADBEEF.
- Byte enables:
  - Preload 0x11223344 at addr 0x05.
  - Write wdata 0xAABBCCDD with be = 0b0101 -> later read returns 0x11BB33DD.
  - Write with be = 0 -> word unchanged, one rvalid pulse.
- LATENCY = 3, continuous req:
  - Reads of 0x00, 0x01, 0x02 are accepted at cycles t, t+3, t+6; gnt = 0 at t+1, t+2, t+4, t+5.
  - rvalid at t+3, t+6, t+9, returning the three words in order.
- Back-to-back at LATENCY = 1: 8 consecutive writes to 0x00..0x07, then 8 reads -> one accept and one rvalid per cycle, no gaps, data matches.
- Reset mid-operation, LATENCY = 4:
  - Write 0xCAFEF00D to addr 0x20, then assert rst_n = 0 two cycles after acceptance -> no rvalid for that request.
  - After release, a read of 0x20 returns 0xCAFEF00D.

Source files
------------

// File: rtl/data_mem.sv
// Word-addressed data RAM for the load/store unit with a req/gnt/rvalid handshake,
// byte-enabled writes and a fixed response latency of LATENCY cycles.
module data_mem #(
  parameter int unsigned AWIDTH  = 8,
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  output logic                gnt,
  input  logic                we,
  input  logic [DWIDTH/8-1:0] be,
  input  logic [AWIDTH-1:0]   addr,
  input  logic [DWIDTH-1:0]   wdata,
  output logic                rvalid,
  output logic [DWIDTH-1:0]   rdata
);

  localparam int unsigned NumBytes = DWIDTH / 8;
  localparam int unsigned Depth    = 2 ** AWIDTH;
  localparam logic [2:0]  LastCnt  = 3'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic [DWIDTH-1:0]   mem [Depth];
  logic                accept;

  assign accept = req & gnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    rvalid  = 1'b0;
    unique case (state_q)
      StIdle: gnt = rst_n;
      StWait: begin
        if (cnt_q == LastCnt) begin
          state_d = StResp;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StResp: begin
        rvalid  = 1'b1;
        gnt     = rst_n;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // An accepted request overrides the default return to idle (back-to-back case).
    if (accept) begin
      if (LATENCY == 1) begin
        state_d = StResp;
      end else begin
        state_d = StWait;
        cnt_d   = 3'd1;
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (accept) begin
      rdata_d = we ? '0 : mem[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // The array is deliberately not reset; accepted writes survive a later reset.
  always_ff @(posedge clk) begin
    if (accept && we) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rvalid ? rdata_q : '0;

endmodule
